fifo_arb: RTL and testbench
===========================

# fifo_arb

Multi-channel buffering stage: NUM_CH independent valid/ready input channels, each with its own DEPTH-entry FIFO, merged onto a single valid/ready output by a work-conserving round-robin arbiter. Successor to the single-channel FIFO; used where several producers share one consumer. Adds per-channel occupancy, per-channel flush, a channel tag on output and output-stability under backpressure.

## Interface
- WIDTH, 8, data word width
- DEPTH, 10, entries per channel; any value ≥ 2, power of two not required
- NUM_CH, 4, number of input channels; ≥ 1
- (derived) CH_W = max(1, clog2(NUM_CH)); CNT_W = clog2(DEPTH+1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- data_in  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- data_in_val  in  NUM_CH  per-channel valid
- data_in_rdy  out  NUM_CH  per-channel ready
- flush  in  NUM_CH  per-channel synchronous clear
- data_out  out  WIDTH  head word of granted channel; 0 when data_out_val=0
- data_out_ch  out  CH_W  index of granted channel; 0 when data_out_val=0
- data_out_val  out  1  output valid
- data_out_rdy  in  1  consumer ready
- count  out  NUM_CH*CNT_W  per-channel occupancy, channel c at [c*CNT_W +: CNT_W]

## Operation
- Push on channel c when data_in_val[c] & data_in_rdy[c] at a rising edge; pop of granted channel when data_out_val & data_out_rdy.
- data_in_rdy[c] = reset & !flush[c] & (count[c] < DEPTH); depends only on registered state and flush, never on data_out_rdy.
- Read/write pointers wrap DEPTH-1 → 0; count[c] += push − pop; push and pop on the same channel in one cycle leave count unchanged.
- Full channel: rdy=0, no push even if a pop from it occurs the same cycle.
- Arbiter states ARB_FREE, ARB_LOCKED; priority pointer rr (CH_W bits).
- ARB_FREE: grant = first non-empty channel searching rr, rr+1, … mod NUM_CH; data_out_val = any channel non-empty.
- ARB_FREE & val & !rdy → ARB_LOCKED, grant held in register; ARB_LOCKED holds data_out/data_out_ch stable regardless of other channels filling.
- Any pop → ARB_FREE, rr ← grant+1 mod NUM_CH (NUM_CH−1 wraps to 0). rr unchanged when no pop.
- flush[c]: count[c], pointers of c ← 0 next edge; flush wins over a push (none possible, rdy=0) and over a pop on c (pop word discarded, consumer still sees handshake). If locked channel is flushed, arbiter → ARB_FREE; this is the only case data_out_val may drop without a pop.
- Reset (reset=0): all counts, pointers 0; rr=0; ARB_FREE; data_in_rdy=0, data_out_val=0, data_out=0, data_out_ch=0, count=0. Storage array not reset. Reset mid-transfer discards all contents.

## Timing
- Write-to-output latency 1 cycle: word pushed at edge N into an empty system is visible with data_out_val=1 after edge N; no combinational in→out bypass.
- Full throughput: one pop per cycle sustained when any channel holds data; each channel accepts one push per cycle while not full.
- count reflects state after the last edge (registered).
- data_in_rdy[c] rises the cycle after a pop brings count[c] below DEPTH.
- Fairness: with all channels continuously non-empty and data_out_rdy=1, grants cycle 0,1,…,NUM_CH−1,0.

## Structure
- Package fifo_arb_pkg: arb_state_t enum {ARB_FREE, ARB_LOCKED}, clog2-based width helper for CH_W/CNT_W.
- Sub-module fifo_arb_ch: single-channel storage, wrap pointers, count, full/empty; instantiated NUM_CH times by generate. Arbiter, lock register and output mux live in top.

## Test plan
- Reset: hold reset=0 3 cycles with data_in_val=all ones → no pushes, data_in_rdy=0, data_out_val=0, count=0; release → data_in_rdy=4'b1111 next cycle.
- Fill ch2 with 10 words 0x20..0x29, data_out_rdy=0 → data_in_rdy[2]=0 after 10th, count[2]=10; 11th word held; drain → words out in order, data_out_ch=2.
- All 4 channels loaded with 3 words each, data_out_rdy=1 → output channel sequence 0,1,2,3,0,1,2,3,0,1,2,3, 12 consecutive valid cycles.
- Lock: only ch3 non-empty, data_out_rdy=0 for 5 cycles while ch0 is pushed → data_out_ch stays 3, data_out stable; on rdy ch3 popped, next grant ch0.
- Flush ch1 (count 6) while granted and locked → count[1]=0 next cycle, arbiter moves to next non-empty channel; push on ch1 during flush not accepted.
- Random 2000-cycle val/rdy stimulus on all ports vs. per-channel scoreboard: no loss, no duplication, per-channel order preserved, count matches model every cycle.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the multi-channel FIFO arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to index n values, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_arb_ch.sv
// One input channel: DEPTH-entry circular buffer with wrap pointers,
// occupancy count and a synchronous flush.
module fifo_arb_ch
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10,
    localparam int CNT_W = width_of(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_val,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_rdy,
    input  logic             flush,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = width_of(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_rdy  = reset & ~flush & ~full;
    assign push    = wr_val & wr_rdy;
    assign pop_ok  = pop & ~empty;
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // A pop that coincides with flush is simply swallowed here.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; count and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/fifo_arb.sv
// NUM_CH independent channel FIFOs merged onto one valid/ready output by a
// work-conserving round-robin arbiter that locks its grant under backpressure.
module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 10,
    parameter int NUM_CH = 4,
    localparam int CH_W  = width_of(NUM_CH),
    localparam int CNT_W = width_of(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]       data_in_val,
    output logic [NUM_CH-1:0]       data_in_rdy,
    input  logic [NUM_CH-1:0]       flush,
    output logic [WIDTH-1:0]        data_out,
    output logic [CH_W-1:0]         data_out_ch,
    output logic                    data_out_val,
    input  logic                    data_out_rdy,
    output logic [NUM_CH*CNT_W-1:0] count
);

    logic [WIDTH-1:0]  head [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] non_empty;
    logic [NUM_CH-1:0] pop_vec;

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]   grant_free;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   grant;
    logic              out_val;
    logic              pop_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            fifo_arb_ch #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .wr_val  (data_in_val[gi]),
                .wr_data (data_in[gi*WIDTH +: WIDTH]),
                .wr_rdy  (data_in_rdy[gi]),
                .flush   (flush[gi]),
                .pop     (pop_vec[gi]),
                .rd_data (head[gi]),
                .count   (count[gi*CNT_W +: CNT_W]),
                .empty   (empty[gi])
            );
            assign non_empty[gi] = ~empty[gi];
            assign pop_vec[gi]   = pop_any & (grant == CH_W'(gi));
        end
    endgenerate

    // Scan from the far end back toward rr so the last hit is the nearest one.
    always_comb begin
        grant_free = rr_q;
        cand       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (int'(rr_q) + i >= NUM_CH) begin
                cand = CH_W'(int'(rr_q) + i - NUM_CH);
            end else begin
                cand = CH_W'(int'(rr_q) + i);
            end
            if (non_empty[cand]) begin
                grant_free = cand;
            end
        end
    end

    // A locked channel stays non-empty until it is popped or flushed,
    // both of which release the lock, so any-non-empty is the valid.
    assign grant   = (state_q == ARB_LOCKED) ? lock_ch_q : grant_free;
    assign out_val = reset & (|non_empty);
    assign pop_any = out_val & data_out_rdy;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        lock_ch_d = lock_ch_q;
        if (pop_any) begin
            state_d = ARB_FREE;
            rr_d    = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end else if (out_val) begin
            if (flush[grant]) begin
                state_d = ARB_FREE;
            end else begin
                state_d   = ARB_LOCKED;
                lock_ch_d = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_FREE;
            rr_q      <= '0;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign data_out_val = out_val;
    assign data_out     = out_val ? head[grant] : '0;
    assign data_out_ch  = out_val ? grant : '0;

endmodule

// File: tb/tb_fifo_arb.sv
// Self-checking bench for fifo_arb: queue-based reference model checked every
// cycle, a fill/drain vector table, directed arbitration sequences, random traffic.
module tb_fifo_arb;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 10;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH*WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]       data_in_val;
    logic [NUM_CH-1:0]       data_in_rdy;
    logic [NUM_CH-1:0]       flush;
    logic [WIDTH-1:0]        data_out;
    logic [CH_W-1:0]         data_out_ch;
    logic                    data_out_val;
    logic                    data_out_rdy;
    logic [NUM_CH*CNT_W-1:0] count;

    always #5 clk = ~clk;

    fifo_arb #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_in_val  (data_in_val),
        .data_in_rdy  (data_in_rdy),
        .flush        (flush),
        .data_out     (data_out),
        .data_out_ch  (data_out_ch),
        .data_out_val (data_out_val),
        .data_out_rdy (data_out_rdy),
        .count        (count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one queue per channel plus the arbitration rules.
    logic [WIDTH-1:0] mq [NUM_CH][$];
    int               m_rr = 0;
    bit               m_locked = 1'b0;
    int               m_lch = 0;
    bit               e_val;
    int               e_ch;
    logic [WIDTH-1:0] e_data;
    bit               chk_en = 1'b0;

    typedef struct {
        logic             in_val;
        logic [WIDTH-1:0] din;
        logic             out_rdy;
        logic             e_val;
        logic [WIDTH-1:0] e_data;
        logic             e_rdy2;
        logic [CNT_W-1:0] e_cnt2;
    } vec_t;

    vec_t tbl [22];
    int   val_p [4] = '{60, 15, 30, 10};
    int   rdy_p [4] = '{30, 90, 60, 95};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_rdy(input int c);
        return (reset === 1'b1) && (flush[c] === 1'b0) && (mq[c].size() < DEPTH);
    endfunction

    task automatic model_predict();
        e_val  = 1'b0;
        e_ch   = 0;
        e_data = '0;
        if (reset === 1'b1) begin
            if (m_locked) begin
                e_val = 1'b1;
                e_ch  = m_lch;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    int c = (m_rr + i) % NUM_CH;
                    if (!e_val && mq[c].size() > 0) begin
                        e_val = 1'b1;
                        e_ch  = c;
                    end
                end
            end
            if (e_val) e_data = mq[e_ch][0];
        end
    endtask

    task automatic check_phase();
        @(negedge clk);
        model_predict();
        if (chk_en) begin
            chk("out_val", data_out_val, e_val);
            chk("out_ch", data_out_ch, e_val ? e_ch : 0);
            chk("out_data", data_out, e_data);
            for (int c = 0; c < NUM_CH; c++) begin
                chk($sformatf("in_rdy[%0d]", c), data_in_rdy[c], m_rdy(c));
                chk($sformatf("count[%0d]", c), count[c*CNT_W +: CNT_W], mq[c].size());
            end
        end
    endtask

    task automatic commit_phase();
        bit                pop;
        logic [NUM_CH-1:0] acc;
        @(posedge clk);
        if (reset !== 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            m_rr     = 0;
            m_locked = 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) acc[c] = data_in_val[c] && m_rdy(c);
            pop = e_val && data_out_rdy;
            if (pop) begin
                if (!flush[e_ch]) void'(mq[e_ch].pop_front());
                m_rr     = (e_ch + 1) % NUM_CH;
                m_locked = 1'b0;
            end else if (e_val) begin
                m_locked = !flush[e_ch];
                m_lch    = e_ch;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) mq[c].push_back(data_in[c*WIDTH +: WIDTH]);
                if (flush[c]) mq[c].delete();
            end
        end
        #1;
    endtask

    task automatic cycle();
        check_phase();
        commit_phase();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        data_in_val  = '0;
        flush        = '0;
        data_out_rdy = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        data_in      = '0;
        data_in_val  = '0;
        flush        = '0;
        data_out_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset held with all valids high: nothing accepted.
        data_in_val = '1;
        data_in     = $urandom();
        for (int i = 0; i < 3; i++) begin
            check_phase();
            chk("rst_in_rdy", data_in_rdy, 0);
            chk("rst_out_val", data_out_val, 0);
            chk("rst_count", count, 0);
            commit_phase();
        end
        reset       = 1'b1;
        data_in_val = '0;
        check_phase();
        chk("release_in_rdy", data_in_rdy, 4'hF);
        commit_phase();

        // Fill channel 2 to full with backpressure, then drain it.
        for (int k = 0; k <= 10; k++) begin
            tbl[k].in_val  = 1'b1;
            tbl[k].din     = 8'(32'h20 + k);
            tbl[k].out_rdy = 1'b0;
            tbl[k].e_val   = (k > 0);
            tbl[k].e_data  = (k > 0) ? 8'h20 : 8'h00;
            tbl[k].e_rdy2  = (k < 10);
            tbl[k].e_cnt2  = 4'(k);
        end
        for (int j = 0; j <= 10; j++) begin
            tbl[11+j].in_val  = 1'b0;
            tbl[11+j].din     = 8'h00;
            tbl[11+j].out_rdy = 1'b1;
            tbl[11+j].e_val   = (j < 10);
            tbl[11+j].e_data  = (j < 10) ? 8'(32'h20 + j) : 8'h00;
            tbl[11+j].e_rdy2  = (j > 0);
            tbl[11+j].e_cnt2  = 4'(10 - j);
        end
        foreach (tbl[v]) begin
            data_in                    = '0;
            data_in[2*WIDTH +: WIDTH]  = tbl[v].din;
            data_in_val                = {1'b0, tbl[v].in_val, 2'b00};
            data_out_rdy               = tbl[v].out_rdy;
            check_phase();
            chk("tbl_val", data_out_val, tbl[v].e_val);
            chk("tbl_ch", data_out_ch, tbl[v].e_val ? 2 : 0);
            chk("tbl_data", data_out, tbl[v].e_data);
            chk("tbl_rdy2", data_in_rdy[2], tbl[v].e_rdy2);
            chk("tbl_cnt2", count[2*CNT_W +: CNT_W], tbl[v].e_cnt2);
            commit_phase();
        end

        // Round-robin fairness: 3 words in every channel, consumer always ready.
        do_reset();
        data_in_val = '1;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < NUM_CH; c++) data_in[c*WIDTH +: WIDTH] = 8'((c << 4) | w);
            cycle();
        end
        data_in_val  = '0;
        data_out_rdy = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            check_phase();
            if (i < 12) begin
                chk("rr_val", data_out_val, 1);
                chk("rr_ch", data_out_ch, i % NUM_CH);
                chk("rr_data", data_out, ((i % NUM_CH) << 4) | (i / NUM_CH));
            end else begin
                chk("rr_idle", data_out_val, 0);
            end
            commit_phase();
        end

        // Lock: channel 3 held on the output while channel 0 fills.
        do_reset();
        data_in                   = '0;
        data_in[3*WIDTH +: WIDTH] = 8'hA5;
        data_in_val               = 4'b1000;
        cycle();
        for (int i = 0; i < 5; i++) begin
            data_in_val        = 4'b0001;
            data_in[WIDTH-1:0] = 8'(32'h50 + i);
            check_phase();
            chk("lock_ch", data_out_ch, 3);
            chk("lock_data", data_out, 8'hA5);
            commit_phase();
        end
        data_in_val  = '0;
        data_out_rdy = 1'b1;
        check_phase();
        chk("lock_pop_ch", data_out_ch, 3);
        commit_phase();
        check_phase();
        chk("lock_next_ch", data_out_ch, 0);
        chk("lock_next_data", data_out, 8'h50);
        commit_phase();

        // Flush the locked channel 1 while a push is attempted on it.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            data_in[1*WIDTH +: WIDTH] = 8'(32'h10 + i);
            data_in[2*WIDTH +: WIDTH] = 8'h77;
            data_in_val               = (i == 0) ? 4'b0110 : 4'b0010;
            cycle();
        end
        flush                     = 4'b0010;
        data_in_val               = 4'b0010;
        data_in[1*WIDTH +: WIDTH] = 8'hEE;
        check_phase();
        chk("flush_cnt_before", count[1*CNT_W +: CNT_W], 6);
        chk("flush_in_rdy1", data_in_rdy[1], 0);
        chk("flush_ch", data_out_ch, 1);
        commit_phase();
        flush       = '0;
        data_in_val = '0;
        check_phase();
        chk("flush_cnt1", count[1*CNT_W +: CNT_W], 0);
        chk("flush_next_ch", data_out_ch, 2);
        chk("flush_next_data", data_out, 8'h77);
        commit_phase();

        // Random traffic in four load phases, with occasional flush and reset.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int ph = n / 500;
            reset   = ($urandom_range(499) != 0);
            data_in = $urandom();
            for (int c = 0; c < NUM_CH; c++) begin
                data_in_val[c] = ($urandom_range(99) < val_p[ph]);
                flush[c]       = ($urandom_range(99) < 2);
            end
            data_out_rdy = ($urandom_range(99) < rdy_p[ph]);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
